// File: rtl/way_select_controller.sv
// way_select_controller
//
// Sequences the 8-way line-select multiplexor of the L2 data array. For each
// request the tag stage hands over hit, valid and dirty vectors. The block
// picks the hit way on a hit. On a miss it picks a victim: the first invalid
// way, or the tree pseudo-LRU choice when every way is valid. It drives the
// mux select and holds it until the response is consumed, and it flags misses
// whose victim must be written back first.
//
// Parameters:
//   ways     number of ways (power of two, >= 2); select is $clog2(ways) bits
//   setBits  set index width; one (ways-1)-bit PLRU tree per set
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   reqValid/reqReady request handshake (single outstanding request)
//   reqSet            set index of the request
//   hitVec            per-way tag match
//   validVec          per-way line valid
//   dirtyVec          per-way line dirty
//   select/selValid   registered mux select and its qualifier
//   rspValid/rspReady response handshake
//   rspHit            the request hit
//   rspWay            chosen way (always equal to select)
//   rspEvict          miss whose victim is valid and dirty (writeback needed)
//
// Optional feature (macro WAY_SELECT_MULTIHIT_CHECK_EN):
//   adds output rspMultiHit, high when more than one hitVec bit was set.
//   The way is still the lowest hitting index.

module way_select_controller #(
  parameter int ways    = 8,
  parameter int setBits = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [setBits-1:0]       reqSet,
  input  logic [ways-1:0]          hitVec,
  input  logic [ways-1:0]          validVec,
  input  logic [ways-1:0]          dirtyVec,
  output logic [$clog2(ways)-1:0]  select,
  output logic                     selValid,
  output logic                     rspValid,
  input  logic                     rspReady,
  output logic                     rspHit,
  output logic [$clog2(ways)-1:0]  rspWay,
  output logic                     rspEvict
`ifdef WAY_SELECT_MULTIHIT_CHECK_EN
  ,
  output logic                     rspMultiHit
`endif
);

  localparam int selW    = $clog2(ways);
  localparam int numSets = 2 ** setBits;
  localparam int nodes   = ways - 1;

  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    RESPOND
  } stateT;

  stateT               state;
  logic [setBits-1:0]  setReg;
  logic [ways-1:0]     hitReg;
  logic [ways-1:0]     validReg;
  logic [ways-1:0]     dirtyReg;
  logic [nodes-1:0]    plru [numSets];

  logic [nodes-1:0]    setPlru;
  logic [nodes-1:0]    touchedPlru;
  logic [selW-1:0]     hitWay;
  logic [selW-1:0]     freeWay;
  logic [selW-1:0]     victimWay;
  logic [selW-1:0]     decidedWay;
  logic                decidedHit;
  logic                decidedEvict;
  logic                anyFree;

  assign setPlru = plru[setReg];

  // Way decision for the registered request. Scanning from the top down means
  // the last match written is the lowest index, which is the priority we want
  // for both hits and free ways. The PLRU walk goes root to leaf, each node
  // bit choosing the lower (0) or upper (1) half; the chosen bits, MSB first,
  // form the victim way. Node lookups compare against every node index rather
  // than indexing with a computed value so the walk stays a plain mux tree.
  // A dirty victim only needs writeback when it was valid, which is only the
  // case on the all-valid PLRU path.
  always_comb begin
    int   node;
    logic b;
    node       = 0;
    b          = 1'b0;
    hitWay     = '0;
    freeWay    = '0;
    victimWay  = '0;
    decidedHit = |hitReg;
    anyFree    = ~&validReg;

    for (int i = ways - 1; i >= 0; i--) begin
      if (hitReg[i]) hitWay = selW'(i);
      if (!validReg[i]) freeWay = selW'(i);
    end

    for (int lvl = 0; lvl < selW; lvl++) begin
      b = 1'b0;
      for (int n = 0; n < nodes; n++) begin
        if (n == node) b = setPlru[n];
      end
      victimWay = (victimWay << 1) | selW'(b);
      node      = 2 * node + 1 + int'(b);
    end

    if (decidedHit) begin
      decidedWay   = hitWay;
      decidedEvict = 1'b0;
    end else if (anyFree) begin
      decidedWay   = freeWay;
      decidedEvict = 1'b0;
    end else begin
      decidedWay   = victimWay;
      decidedEvict = dirtyReg[victimWay];
    end
  end

  // New PLRU tree for the registered set once the chosen way is touched: every
  // node on the root-to-leaf path of that way is set to point away from it,
  // so the next victim walk steers elsewhere. Nodes off the path are kept.
  always_comb begin
    int              node;
    logic            b;
    logic [selW-1:0] wayBits;
    node        = 0;
    b           = 1'b0;
    wayBits     = rspWay;
    touchedPlru = setPlru;

    for (int lvl = 0; lvl < selW; lvl++) begin
      b = wayBits[selW-1];
      for (int n = 0; n < nodes; n++) begin
        if (n == node) touchedPlru[n] = ~b;
      end
      node    = 2 * node + 1 + int'(b);
      wayBits = wayBits << 1;
    end
  end

  // Controller sequence: accept and capture the request in IDLE, register the
  // decision in DECIDE, then hold every output in RESPOND until the consumer
  // takes the response. The PLRU is only written at the response handshake,
  // so a reset that lands mid-transaction leaves no trace in the trees. The
  // response fields and select are left alone on return to IDLE so the mux
  // keeps its last setting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      reqReady <= 1'b1;
      setReg   <= '0;
      hitReg   <= '0;
      validReg <= '0;
      dirtyReg <= '0;
      select   <= '0;
      selValid <= 1'b0;
      rspValid <= 1'b0;
      rspHit   <= 1'b0;
      rspWay   <= '0;
      rspEvict <= 1'b0;
`ifdef WAY_SELECT_MULTIHIT_CHECK_EN
      rspMultiHit <= 1'b0;
`endif
      for (int k = 0; k < numSets; k++) begin
        plru[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            setReg   <= reqSet;
            hitReg   <= hitVec;
            validReg <= validVec;
            dirtyReg <= dirtyVec;
            reqReady <= 1'b0;
            state    <= DECIDE;
          end
        end
        DECIDE: begin
          select   <= decidedWay;
          rspWay   <= decidedWay;
          rspHit   <= decidedHit;
          rspEvict <= decidedEvict;
`ifdef WAY_SELECT_MULTIHIT_CHECK_EN
          rspMultiHit <= |(hitReg & (hitReg - ways'(1)));
`endif
          selValid <= 1'b1;
          rspValid <= 1'b1;
          state    <= RESPOND;
        end
        RESPOND: begin
          if (rspValid && rspReady) begin
            plru[setReg] <= touchedPlru;
            selValid     <= 1'b0;
            rspValid     <= 1'b0;
            reqReady     <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
